alu_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_mul_iter.sv | 65 ++++++
 rtl/alu_seq.sv | 166 ++++++++++++++++
 tb/tb_alu_seq.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
//==============================================================================
// Module : alu_pkg
// Brief  : Shared opcode, FSM state and status-flag types for the sequential ALU.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_NOT = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_LSL = 3'b110,
        OP_MUL = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } alu_state_t;

    typedef struct packed {
        logic Z;
        logic N;
        logic V;
        logic C;
    } flags_t;

endpackage

`default_nettype wire

// File: rtl/alu_mul_iter.sv
//==============================================================================
// Module : alu_mul_iter
// Brief  : Iterative shift-add unsigned multiplier, one partial product per cycle.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module alu_mul_iter #(
    parameter  int DATA_WIDTH = 16,
    localparam int CNT_W      = $clog2(DATA_WIDTH) + 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      i_start,
    input  logic [DATA_WIDTH-1:0]     i_a,
    input  logic [DATA_WIDTH-1:0]     i_b,
    output logic                      o_done,
    output logic [2*DATA_WIDTH-1:0]   o_product,
    output logic [CNT_W-1:0]          o_count
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DATA_WIDTH - 1);

    logic [2*DATA_WIDTH-1:0] r_mcand;
    logic [2*DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_busy;
    logic [2*DATA_WIDTH-1:0] w_acc_next;

    // o_product is the accumulator value after the current step, so the
    // caller can capture the final product on the same edge as the last step.
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign o_product  = w_acc_next;
    assign o_done     = r_busy && (r_cnt == c_LAST);
    assign o_count    = r_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (i_start) begin
            r_mcand  <= {{DATA_WIDTH{1'b0}}, i_a};
            r_acc    <= '0;
            r_mplier <= i_b;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
//==============================================================================
// Module : alu_seq
// Brief  : Multi-cycle ALU with valid/ready handshakes and registered Z/N/V/C.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module alu_seq
    import alu_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    localparam int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] Ain,
    input  logic [DATA_WIDTH-1:0] Bin,
    input  logic [2:0]            ALUop,
    input  logic                  flag_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  Z,
    output logic                  N,
    output logic                  V,
    output logic                  C
);

    localparam int c_MSB   = DATA_WIDTH - 1;
    localparam int c_CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_MUL_LAST = c_CNT_W'(DATA_WIDTH - 1);

    alu_state_t              r_state;
    logic [DATA_WIDTH-1:0]   r_out;
    flags_t                  r_flags;
    logic                    r_flag_en;

    alu_op_t                 w_op;
    logic                    w_accept;
    logic                    w_mul_start;
    logic                    w_mul_done;
    logic                    w_mul_fin;
    logic [2*DATA_WIDTH-1:0] w_mul_prod;
    logic [c_CNT_W-1:0]      w_mul_cnt;
    logic [DATA_WIDTH:0]     w_sum;
    logic [DATA_WIDTH:0]     w_diff;
    logic [DATA_WIDTH:0]     w_shl;
    logic [SHAMT_W-1:0]      w_shamt;
    logic [DATA_WIDTH-1:0]   w_res;
    flags_t                  w_flags;
    flags_t                  w_mul_flags;

    assign w_op        = alu_op_t'(ALUop);
    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign w_accept    = in_valid && in_ready;
    assign w_mul_start = w_accept && (w_op == OP_MUL);
    assign w_mul_fin   = (r_state == S_MUL) && w_mul_done && (w_mul_cnt == c_MUL_LAST);

    assign w_sum   = {1'b0, Ain} + {1'b0, Bin};
    assign w_diff  = {1'b0, Ain} - {1'b0, Bin};
    assign w_shamt = Bin[SHAMT_W-1:0];
    // One extra bit above the result catches the last bit shifted out.
    assign w_shl   = {1'b0, Ain} << w_shamt;

    always_comb begin
        w_res   = '0;
        w_flags = '0;
        case (w_op)
            OP_ADD: begin
                w_res     = w_sum[c_MSB:0];
                w_flags.C = w_sum[DATA_WIDTH];
                w_flags.V = (Ain[c_MSB] == Bin[c_MSB]) && (w_sum[c_MSB] != Ain[c_MSB]);
            end
            OP_SUB: begin
                w_res     = w_diff[c_MSB:0];
                w_flags.C = ~w_diff[DATA_WIDTH];
                w_flags.V = (Ain[c_MSB] != Bin[c_MSB]) && (w_diff[c_MSB] != Ain[c_MSB]);
            end
            OP_AND:  w_res = Ain & Bin;
            OP_NOT:  w_res = ~Bin;
            OP_OR:   w_res = Ain | Bin;
            OP_XOR:  w_res = Ain ^ Bin;
            OP_LSL: begin
                w_res     = w_shl[c_MSB:0];
                w_flags.C = w_shl[DATA_WIDTH];
            end
            default: w_res = '0;
        endcase
        w_flags.Z = (w_res == '0);
        w_flags.N = w_res[c_MSB];
    end

    always_comb begin
        w_mul_flags   = '0;
        w_mul_flags.Z = (w_mul_prod[c_MSB:0] == '0);
        w_mul_flags.N = w_mul_prod[c_MSB];
        w_mul_flags.V = |w_mul_prod[2*DATA_WIDTH-1:DATA_WIDTH];
    end

    alu_mul_iter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mul (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_start   (w_mul_start),
        .i_a       (Ain),
        .i_b       (Bin),
        .o_done    (w_mul_done),
        .o_product (w_mul_prod),
        .o_count   (w_mul_cnt)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_out     <= '0;
            r_flags   <= '0;
            r_flag_en <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_flag_en <= flag_en;
                        if (w_op == OP_MUL) begin
                            r_state <= S_MUL;
                        end else begin
                            r_out <= w_res;
                            if (flag_en) begin
                                r_flags <= w_flags;
                            end
                            r_state <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    if (w_mul_fin) begin
                        r_out <= w_mul_prod[c_MSB:0];
                        if (r_flag_en) begin
                            r_flags <= w_mul_flags;
                        end
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out = r_out;
    assign Z   = r_flags.Z;
    assign N   = r_flags.N;
    assign V   = r_flags.V;
    assign C   = r_flags.C;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
//==============================================================================
// Module : tb_alu_seq
// Brief  : Directed self-checking bench for alu_seq with an expected-result queue.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alu_seq;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] Ain;
    logic [15:0] Bin;
    logic [2:0]  ALUop;
    logic        flag_en;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic        Z, N, V, C;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] o;
        logic [3:0]  f;
        int          lat;
    } exp_t;

    exp_t sb[$];

    alu_seq #(.DATA_WIDTH(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Ain       (Ain),
        .Bin       (Bin),
        .ALUop     (ALUop),
        .flag_en   (flag_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .Z         (Z),
        .N         (N),
        .V         (V),
        .C         (C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Drive one operation, wait for its result, optionally stall the output.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] op, input logic fe, input logic [15:0] eo,
                          input logic [3:0] ef, input int el, input int hold);
        exp_t e;
        int   lat;
        sb.push_back('{o: eo, f: ef, lat: el});
        out_ready = (hold == 0);
        @(negedge clk);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        Ain = a; Bin = b; ALUop = op; flag_en = fe; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
        e = sb.pop_front();
        check({tag, "_latency"}, lat, e.lat);
        check({tag, "_out"}, {16'd0, out}, {16'd0, e.o});
        check({tag, "_flags"}, {28'd0, Z, N, V, C}, {28'd0, e.f});
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, "_hold_out"}, {16'd0, out}, {16'd0, e.o});
            check({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
            check({tag, "_hold_flags"}, {28'd0, Z, N, V, C}, {28'd0, e.f});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int seen;
        reset_n = 1'b0; in_valid = 1'b0; Ain = '0; Bin = '0; ALUop = '0;
        flag_en = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out", {16'd0, out}, 32'd0);
        check("rst_flags", {28'd0, Z, N, V, C}, 32'd0);

        // flags encoded as {Z,N,V,C}
        run_op("add_ovf",  16'h7FFF, 16'h0001, 3'b000, 1'b1, 16'h8000, 4'b0110, 1, 0);
        run_op("sub_eq",   16'h0005, 16'h0005, 3'b001, 1'b1, 16'h0000, 4'b1001, 1, 0);
        run_op("sub_neg",  16'h0003, 16'h0005, 3'b001, 1'b1, 16'hFFFE, 4'b0100, 1, 0);
        run_op("mul_ovf",  16'h0100, 16'h0100, 3'b111, 1'b1, 16'h0000, 4'b1010, 17, 0);
        run_op("mul_small",16'h0012, 16'h0034, 3'b111, 1'b1, 16'h03A8, 4'b0000, 17, 0);
        run_op("lsl_1",    16'h8001, 16'h0001, 3'b110, 1'b1, 16'h0002, 4'b0001, 1, 0);
        run_op("lsl_0",    16'h8001, 16'h0000, 3'b110, 1'b1, 16'h8001, 4'b0100, 1, 0);
        run_op("lsl_mask", 16'h8001, 16'h0011, 3'b110, 1'b1, 16'h0002, 4'b0001, 1, 0);
        run_op("and",      16'hF0F0, 16'hFF00, 3'b010, 1'b1, 16'hF000, 4'b0100, 1, 0);
        run_op("or",       16'h0F00, 16'h00F0, 3'b100, 1'b1, 16'h0FF0, 4'b0000, 1, 0);
        run_op("xor",      16'hFFFF, 16'hFFFF, 3'b101, 1'b1, 16'h0000, 4'b1000, 1, 0);
        run_op("not",      16'h1234, 16'h00FF, 3'b011, 1'b1, 16'hFF00, 4'b0100, 1, 0);
        run_op("z_set",    16'h0005, 16'h0005, 3'b001, 1'b1, 16'h0000, 4'b1001, 1, 0);
        run_op("add_nofl", 16'h0001, 16'h0001, 3'b000, 1'b0, 16'h0002, 4'b1001, 1, 3);
        run_op("mul_nofl", 16'h0003, 16'h0004, 3'b111, 1'b0, 16'h000C, 4'b1001, 17, 0);

        // Reset in the fifth cycle of a multiply discards it.
        @(negedge clk);
        Ain = 16'h0012; Bin = 16'h0034; ALUop = 3'b111; flag_en = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mrst_out", {16'd0, out}, 32'd0);
        check("mrst_flags", {28'd0, Z, N, V, C}, 32'd0);
        check("mrst_in_ready", {31'd0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mrst_no_stale", seen, 0);

        run_op("mul_after",16'h00FF, 16'h0101, 3'b111, 1'b1, 16'hFFFF, 4'b0100, 17, 0);
        check("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
